// File: rtl/trap_ctrl_if.sv
// Signal bundle between WBU / pipeline CSR requester, trap_ctrl and the CSR file.
// irq_timer_i exists only when YSYX_23060251_TRAP_IRQ_EN is defined.
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            is_ecall_i;
    logic            is_ebreak_i;
    logic            is_illegal_i;
    logic            is_mret_i;
    logic [XLEN-1:0] pc_i;
    logic            csr_req_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic            csr_gnt_o;
    logic            csr_we_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic [XLEN-1:0] csr_rdata_i;
    logic            mstatus_mie_i;
`ifdef YSYX_23060251_TRAP_IRQ_EN
    logic            irq_timer_i;
`endif
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;

    modport slave (
`ifdef YSYX_23060251_TRAP_IRQ_EN
        input  irq_timer_i,
`endif
        input  req_valid_i, is_ecall_i, is_ebreak_i, is_illegal_i, is_mret_i, pc_i,
        input  csr_req_i, csr_addr_i, csr_wdata_i, csr_rdata_i, mstatus_mie_i,
        output req_ready_o, csr_gnt_o, csr_we_o, csr_addr_o, csr_wdata_o,
        output redirect_valid_o, redirect_pc_o, busy_o
    );

    modport master (
`ifdef YSYX_23060251_TRAP_IRQ_EN
        output irq_timer_i,
`endif
        output req_valid_i, is_ecall_i, is_ebreak_i, is_illegal_i, is_mret_i, pc_i,
        output csr_req_i, csr_addr_i, csr_wdata_i, csr_rdata_i, mstatus_mie_i,
        input  req_ready_o, csr_gnt_o, csr_we_o, csr_addr_o, csr_wdata_o,
        input  redirect_valid_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer and CSR write-port arbiter between WBU and the machine CSR file.
// Define YSYX_23060251_TRAP_IRQ_EN to enable the machine timer interrupt path.
module trap_ctrl #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(32'd11),
    parameter logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(32'd3),
    parameter logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(32'd2)
`ifdef YSYX_23060251_TRAP_IRQ_EN
    ,parameter logic [XLEN-1:0] CAUSE_MTI    = XLEN'(32'h80000007)
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    trap_ctrl_if.slave  bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam int MIE  = 3;
    localparam int MPIE = 7;

    typedef enum logic [2:0] {
        IDLE, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, FETCH_VEC, RET_STATUS, RET_EPC
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d;

    logic            exc, irq_take, trap_take, accept, seq_accept;
    logic [XLEN-1:0] trap_cause, trap_epc;

    logic            ready, busy, gnt, we, rv;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata, rpc;

    assign exc = bus.is_illegal_i | bus.is_ebreak_i | bus.is_ecall_i;

`ifdef YSYX_23060251_TRAP_IRQ_EN
    // An interrupt traps on an otherwise-clean retirement; epc points past it.
    assign irq_take   = bus.irq_timer_i & bus.mstatus_mie_i & ~exc;
    assign trap_epc   = irq_take ? bus.pc_i + XLEN'(4) : bus.pc_i;
    assign trap_cause = irq_take          ? CAUSE_MTI     :
                        bus.is_illegal_i  ? CAUSE_ILLEGAL :
                        bus.is_ebreak_i   ? CAUSE_EBREAK  : CAUSE_ECALL;
`else
    logic unused_mie;
    assign unused_mie = bus.mstatus_mie_i;
    assign irq_take   = 1'b0;
    assign trap_epc   = bus.pc_i;
    assign trap_cause = bus.is_illegal_i ? CAUSE_ILLEGAL :
                        bus.is_ebreak_i  ? CAUSE_EBREAK  : CAUSE_ECALL;
`endif

    assign trap_take  = irq_take | exc;
    assign accept     = bus.req_valid_i & (state_q == IDLE) & ~rst_i;
    assign seq_accept = accept & (trap_take | bus.is_mret_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        ready   = 1'b0;
        busy    = 1'b1;
        gnt     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        rv      = 1'b0;
        rpc     = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (accept && trap_take) begin
                    state_d = SAVE_EPC;
                    pc_d    = trap_epc;
                    cause_d = trap_cause;
                end else if (accept && bus.is_mret_i) begin
                    state_d = RET_STATUS;
                end
                // A trap/mret taking the port this cycle makes the requester wait.
                if (bus.csr_req_i && !seq_accept) begin
                    gnt   = 1'b1;
                    we    = 1'b1;
                    addr  = bus.csr_addr_i;
                    wdata = bus.csr_wdata_i;
                end
            end
            SAVE_EPC: begin
                we      = 1'b1;
                addr    = ADDR_MEPC;
                wdata   = pc_q;
                state_d = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                we      = 1'b1;
                addr    = ADDR_MCAUSE;
                wdata   = cause_q;
                state_d = UPD_STATUS;
            end
            UPD_STATUS: begin
                we             = 1'b1;
                addr           = ADDR_MSTATUS;
                wdata          = bus.csr_rdata_i;
                wdata[MPIE]    = bus.csr_rdata_i[MIE];
                wdata[MIE]     = 1'b0;
                wdata[12:11]   = 2'b11;
                state_d        = FETCH_VEC;
            end
            FETCH_VEC: begin
                addr    = ADDR_MTVEC;
                rv      = 1'b1;
                rpc     = {bus.csr_rdata_i[XLEN-1:2], 2'b00};
                state_d = IDLE;
            end
            RET_STATUS: begin
                we             = 1'b1;
                addr           = ADDR_MSTATUS;
                wdata          = bus.csr_rdata_i;
                wdata[MIE]     = bus.csr_rdata_i[MPIE];
                wdata[MPIE]    = 1'b1;
                wdata[12:11]   = 2'b11;
                state_d        = RET_EPC;
            end
            RET_EPC: begin
                addr    = ADDR_MEPC;
                rv      = 1'b1;
                rpc     = bus.csr_rdata_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet for as long as reset is held.
        if (rst_i) begin
            ready = 1'b0;
            busy  = 1'b0;
            gnt   = 1'b0;
            we    = 1'b0;
            addr  = '0;
            wdata = '0;
            rv    = 1'b0;
            rpc   = '0;
        end
    end

    assign bus.req_ready_o      = ready;
    assign bus.busy_o           = busy;
    assign bus.csr_gnt_o        = gnt;
    assign bus.csr_we_o         = we;
    assign bus.csr_addr_o       = addr;
    assign bus.csr_wdata_o      = wdata;
    assign bus.redirect_valid_o = rv;
    assign bus.redirect_pc_o    = rpc;
endmodule
